uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port divr, input, 16 bits: receive divisor in clk cycles per bit; driven by the divisor register DIVR.
REQ-004 SHALL have port rxd, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port rx_data, output, 8 bits: last received byte.
REQ-006 SHALL have port rx_valid, output, 1 bit: byte available (LSR data-ready source).
REQ-007 SHALL have port rx_ack, input, 1 bit: single-cycle pulse from the register file when the CPU reads DATA.
REQ-008 SHALL have port frame_err, output, 1 bit: stop bit sampled low for the held byte.
REQ-009 SHALL have port overrun, output, 1 bit: a byte was overwritten before being acknowledged.
REQ-010 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 SHALL pass rxd through a two-flop synchronizer (reset value 1), giving rxd_s; all decisions SHALL use rxd_s only.
REQ-012 SHALL frame 8N1: one start bit, 8 data bits LSB first, one stop bit, no parity.
REQ-013 SHALL latch the effective divisor D = max(divr, 4) on the IDLE->START transition; a divr change mid-frame SHALL have no effect until the next frame.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with one down-counter (16 bits) and one bit index (3 bits).
REQ-015 IDLE: when rxd_s==0, go to START and load the counter for floor(D/2) cycles.
REQ-016 START: on counter expiry, sample rxd_s; 0 -> DATA, counter=D, index=0; 1 (glitch) -> IDLE, no flags change.
REQ-017 DATA: on each expiry, shift rxd_s into the shift register at bit[index] and reload D; after index 7 -> STOP with counter=D.
REQ-018 STOP: on expiry, sample rxd_s and load rx_data from the shift register; set rx_valid=1 and frame_err=~rxd_s; stop=1 -> IDLE, stop=0 -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rxd_s==1, then go to IDLE; a held break SHALL produce exactly one byte (0x00, frame_err=1).
REQ-020 Outputs rx_data, rx_valid, frame_err and overrun SHALL be registered and update on the clock after the stop sample.
REQ-021 If rx_valid==1 at byte completion without a same-cycle rx_ack: rx_data is overwritten and overrun is set to 1 (sticky).
REQ-022 On rx_ack with no completion in the same cycle: clear rx_valid, frame_err and overrun on the next clock.
REQ-023 If rx_ack and byte completion coincide: the new byte wins; rx_valid stays 1, frame_err reflects the new byte, overrun=0.
REQ-024 rx_ack while rx_valid==0 SHALL have no effect.
REQ-025 The receiver SHALL never stall on rx_valid; reception continues regardless of the handshake.

Reset
REQ-026 On rst: state=IDLE, counter=0, index=0, synchronizer=1, shift register=0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0, all immediately (asynchronously).
REQ-027 Reset asserted mid-frame SHALL abort the frame with no partial byte delivered; after release, the line must be seen low in IDLE before a new frame starts.

Verification
REQ-028 divr=16; send 0x37 (rxd falls at cycle 0) -> rx_valid rises at cycle 155+/-2, rx_data=0x37, frame_err=0, overrun=0.
REQ-029 divr=16; rxd low pulse of 4 cycles -> returns to IDLE, rx_valid stays 0, busy high for no more than 10 cycles.
REQ-030 divr=16; send 0xA5 with stop bit 0, line then held low 100 cycles, then high -> exactly one byte: rx_data=0xA5, frame_err=1, state passes through WAIT_HIGH, no second byte.
REQ-031 divr=16; send 0x11 then 0x22 with no rx_ack -> rx_data=0x22, overrun=1; one rx_ack pulse -> rx_valid=0, overrun=0 next cycle.
REQ-032 divr=16; rx_ack pulsed in the exact completion cycle of 0x5A -> rx_valid=1, rx_data=0x5A, overrun=0.
REQ-033 divr=2 (clamped to 4) sending 0xFF, and rst asserted at data bit 3 of a frame -> first case yields 0xFF; second case yields all outputs at reset values and no byte delivered.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized input, mid-bit sampling with a
// per-frame latched divisor, single-entry holding register with overrun flag.
module uart_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] divr,
    input  logic        rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [15:0] div_q, div_n;
    logic [7:0]  shreg, shreg_n;
    logic [1:0]  sync;
    logic        rxd_s;
    logic        done;
    logic [15:0] div_eff;
    logic        expired;

    assign rxd_s   = sync[1];
    assign div_eff = (divr < 16'd4) ? 16'd4 : divr;
    assign expired = (cnt == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rxd};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            div_q <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            div_q <= div_n;
            shreg <= shreg_n;
        end
    end

    // Counter is loaded with N-1 and expires at zero, giving N cycles per interval.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        div_n   = div_q;
        shreg_n = shreg;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_n = START;
                    div_n   = div_eff;
                    cnt_n   = (div_eff >> 1) - 16'd1;
                end
            end
            START: begin
                if (expired) begin
                    if (!rxd_s) begin
                        state_n = DATA;
                        cnt_n   = div_q - 16'd1;
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DATA: begin
                if (expired) begin
                    shreg_n[idx] = rxd_s;
                    cnt_n        = div_q - 16'd1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            STOP: begin
                if (expired) begin
                    done    = 1'b1;
                    state_n = rxd_s ? IDLE : WAIT_HIGH;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (rxd_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A completing byte always wins over a same-cycle acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (done) begin
            rx_data   <= shreg;
            rx_valid  <= 1'b1;
            frame_err <= ~rxd_s;
            if (rx_ack) begin
                overrun <= 1'b0;
            end else if (rx_valid) begin
                overrun <= 1'b1;
            end
        end else if (rx_ack && rx_valid) begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboard of expected bytes, popped and
// compared after each frame completes.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] divr = 16'd16;
    logic        rxd = 1'b1;
    logic        rx_ack = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .divr      (divr),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bt);
        rxd = 1'b0;
        tick(bt);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            tick(bt);
        end
        rxd = stop;
        tick(bt);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
        chk({tag, "_data"}, 32'(rx_data), 32'(e.data));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(e.ferr));
    endtask

    initial begin
        int lat;
        int t0;
        int busy_n;
        int valid_n;

        // reset values while rst is held
        tick(3);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(5);

        // 0x37 at divisor 16, latency from falling edge to rx_valid
        sb.push_back('{data: 8'h37, ferr: 1'b0});
        t0 = cyc;
        lat = -1;
        fork
            send_frame(8'h37, 1'b1, 16);
            begin
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (rx_valid && lat < 0) lat = cyc - t0;
                end
            end
        join
        tick(1);
        chk("latency_155pm2", 32'(lat >= 153 && lat <= 157), 32'd1);
        check_pop("b37");
        chk("b37_ovr", 32'(overrun), 32'd0);
        ack_pulse();
        chk("ack_clears_valid", 32'(rx_valid), 32'd0);

        // 4-cycle start glitch
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        busy_n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
        end
        tick(1);
        chk("glitch_busy_1to10", 32'(busy_n >= 1 && busy_n <= 10), 32'd1);
        chk("glitch_no_byte", 32'(rx_valid), 32'd0);

        // 0xA5 with low stop bit, line held in break
        sb.push_back('{data: 8'hA5, ferr: 1'b1});
        send_frame(8'hA5, 1'b0, 16);
        chk("break_busy_a", 32'(busy), 32'd1);
        tick(100);
        chk("break_busy_b", 32'(busy), 32'd1);
        rxd = 1'b1;
        tick(40);
        check_pop("bA5");
        chk("break_single_byte", 32'(overrun), 32'd0);
        chk("break_idle", 32'(busy), 32'd0);
        ack_pulse();
        chk("ack_clears_ferr", 32'(frame_err), 32'd0);
        chk("ack_clears_valid2", 32'(rx_valid), 32'd0);

        // two bytes without acknowledge
        sb.push_back('{data: 8'h11, ferr: 1'b0});
        send_frame(8'h11, 1'b1, 16);
        tick(5);
        check_pop("b11");
        chk("b11_ovr", 32'(overrun), 32'd0);
        sb.push_back('{data: 8'h22, ferr: 1'b0});
        send_frame(8'h22, 1'b1, 16);
        tick(5);
        check_pop("b22");
        chk("overrun_set", 32'(overrun), 32'd1);
        ack_pulse();
        chk("ovr_ack_valid", 32'(rx_valid), 32'd0);
        chk("ovr_ack_ovr", 32'(overrun), 32'd0);

        // acknowledge coinciding with completion of 0x5A, previous byte pending
        sb.push_back('{data: 8'h3C, ferr: 1'b0});
        send_frame(8'h3C, 1'b1, 16);
        tick(5);
        check_pop("b3C");
        sb.push_back('{data: 8'h5A, ferr: 1'b0});
        fork
            send_frame(8'h5A, 1'b1, 16);
            begin
                tick(154);
                rx_ack = 1'b1;
                tick(1);
                rx_ack = 1'b0;
            end
        join
        tick(2);
        check_pop("b5A");
        chk("coincide_ovr", 32'(overrun), 32'd0);
        ack_pulse();

        // divisor 2 clamps to 4; divr change mid-frame must be ignored
        divr = 16'd2;
        sb.push_back('{data: 8'h96, ferr: 1'b0});
        fork
            send_frame(8'h96, 1'b1, 4);
            begin
                tick(10);
                divr = 16'd16;
            end
        join
        tick(10);
        check_pop("b96_clamp");
        chk("b96_ovr", 32'(overrun), 32'd0);

        // reset during data bit 3, with the 0x96 byte still pending
        rxd = 1'b0;
        tick(16);
        rxd = 1'b1;
        tick(16 * 3 + 8);
        chk("midframe_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(rx_valid), 32'd0);
        chk("arst_data", 32'(rx_data), 32'h00);
        chk("arst_ferr", 32'(frame_err), 32'd0);
        chk("arst_ovr", 32'(overrun), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick(3);
        rst = 1'b0;
        busy_n = 0;
        valid_n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (rx_valid) valid_n++;
        end
        tick(1);
        chk("abort_no_byte", 32'(valid_n), 32'd0);
        chk("abort_no_restart", 32'(busy_n), 32'd0);

        // recovery after reset
        sb.push_back('{data: 8'h4B, ferr: 1'b0});
        send_frame(8'h4B, 1'b1, 16);
        tick(5);
        check_pop("b4B");
        chk("b4B_ovr", 32'(overrun), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
